// File: rtl/eth_avalon_bd_mem.sv
// eth_avalon_bd_mem: dual-port buffer-descriptor RAM for the Avalon Ethernet MAC.
// Port A = host/Avalon slave, port B = TX/RX descriptor engines.
// Ports:
//   clock, reset_n          : rising-edge clock, async active-low reset
//   init_busy               : clear engine running (user writes ignored)
//   collision               : 1-cycle pulse, same-address overlapping-byte dual write
//   wren/byteen/rden/address/data/q _a,_b : per-port write, byte enables,
//                             read enable, word address, write data, read data
module eth_avalon_bd_mem #(
  parameter int DEPTH          = 128,
  parameter int WIDTH          = 32,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW            = $clog2(DEPTH),
  localparam int BW            = WIDTH / 8
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic             init_busy,
  output logic             collision,
  input  logic             wren_a,
  input  logic [BW-1:0]    byteen_a,
  input  logic             rden_a,
  input  logic [AW-1:0]    address_a,
  input  logic [WIDTH-1:0] data_a,
  output logic [WIDTH-1:0] q_a,
  input  logic             wren_b,
  input  logic [BW-1:0]    byteen_b,
  input  logic             rden_b,
  input  logic [AW-1:0]    address_b,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] q_b
);

  localparam logic [0:0]    S_CLEAR = 1'b0;
  localparam logic [0:0]    S_RUN   = 1'b1;
  localparam logic [0:0]    S_INIT  =
    (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic             coll_q, coll_d;
  logic [WIDTH-1:0] r1a_q, r1b_q;
  logic             rva_q, rvb_q;
  logic [WIDTH-1:0] rd_a, rd_b;
  logic             run, a_in, b_in;
  logic             we_a, we_b, same;

  assign run  = (state_q == S_RUN);
  assign a_in = ({1'b0, address_a} < DEPTH_W);
  assign b_in = ({1'b0, address_b} < DEPTH_W);
  assign we_a = run & wren_a & a_in;
  assign we_b = run & wren_b & b_in;
  assign same = (address_a == address_b);

  assign init_busy = ~run;
  assign collision = coll_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (!run) begin
      ptr_d = ptr_q + AW'(1);
      if (ptr_q == LAST) state_d = S_RUN;
    end
  end

  assign coll_d = we_a & we_b & same &
                  (|(byteen_a & byteen_b));

  // Read data reflects this cycle's writes, B first so A wins per byte.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (a_in) rd_a = mem[address_a];
    if (b_in) rd_b = mem[address_b];
    for (int i = 0; i < BW; i++) begin
      if (we_b && byteen_b[i]) begin
        rd_b[8*i +: 8] = data_b[8*i +: 8];
        if (same) rd_a[8*i +: 8] = data_b[8*i +: 8];
      end
      if (we_a && byteen_a[i]) begin
        rd_a[8*i +: 8] = data_a[8*i +: 8];
        if (same) rd_b[8*i +: 8] = data_a[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!run) begin
      mem[ptr_q] <= '0;
    end else begin
      for (int i = 0; i < BW; i++) begin
        if (we_b && byteen_b[i])
          mem[address_b][8*i +: 8] <= data_b[8*i +: 8];
        if (we_a && byteen_a[i])
          mem[address_a][8*i +: 8] <= data_a[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      coll_q  <= 1'b0;
      r1a_q   <= '0;
      r1b_q   <= '0;
      rva_q   <= 1'b0;
      rvb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      coll_q  <= coll_d;
      rva_q   <= rden_a;
      rvb_q   <= rden_b;
      if (rden_a) r1a_q <= run ? rd_a : '0;
      if (rden_b) r1b_q <= run ? rd_b : '0;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [WIDTH-1:0] r2a_q, r2b_q;

    // Second stage only advances behind an actual read.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r2a_q <= '0;
        r2b_q <= '0;
      end else begin
        if (rva_q) r2a_q <= r1a_q;
        if (rvb_q) r2b_q <= r1b_q;
      end
    end

    assign q_a = r2a_q;
    assign q_b = r2b_q;
  end else begin : g_noreg
    logic unused_rv;
    assign unused_rv = rva_q ^ rvb_q;
    assign q_a = r1a_q;
    assign q_b = r1b_q;
  end

endmodule
